// File: rtl/fetch_pkg.sv
// Shared widths, buffer entry layout and FSM encoding for the instruction fetch controller.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam logic [PC_W-1:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               filled;
    } ibuf_entry_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return addr & ~PC_W'(3);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bus bundle between the fetch controller and its PC register, instruction memory and decode.
interface fetch_ctrl_if;
    import fetch_pkg::*;

    logic [PC_W-1:0]    i_pc;
    logic [PC_W-1:0]    o_pc_next;
    logic               o_pc_wren;

    logic               o_imem_req;
    logic [PC_W-1:0]    o_imem_addr;
    logic               i_imem_gnt;
    logic               i_imem_rvalid;
    logic [INSTR_W-1:0] i_imem_rdata;

    logic               i_redirect;
    logic [PC_W-1:0]    i_redirect_pc;

    logic               o_instr_valid;
    logic [INSTR_W-1:0] o_instr;
    logic [PC_W-1:0]    o_instr_pc;
    logic               i_instr_ready;

    modport master (
        input  i_pc,
        output o_pc_next,
        output o_pc_wren,
        output o_imem_req,
        output o_imem_addr,
        input  i_imem_gnt,
        input  i_imem_rvalid,
        input  i_imem_rdata,
        input  i_redirect,
        input  i_redirect_pc,
        output o_instr_valid,
        output o_instr,
        output o_instr_pc,
        input  i_instr_ready
    );

    modport slave (
        output i_pc,
        input  o_pc_next,
        input  o_pc_wren,
        input  o_imem_req,
        input  o_imem_addr,
        output i_imem_gnt,
        output i_imem_rvalid,
        output i_imem_rdata,
        output i_redirect,
        output i_redirect_pc,
        input  o_instr_valid,
        input  o_instr,
        input  o_instr_pc,
        output i_instr_ready
    );

endinterface

// File: rtl/fetch_ibuf.sv
// In-order instruction buffer: entries are allocated at grant, filled by responses and popped by decode.
module fetch_ibuf
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic               clk_sys,
    input  logic               rst_b,
    input  logic               flush,
    input  logic               alloc,
    input  logic [PC_W-1:0]    alloc_pc,
    input  logic               fill,
    input  logic [INSTR_W-1:0] fill_instr,
    input  logic               pop,
    output logic [AW:0]        alloc_cnt,
    output logic [AW:0]        pend_cnt,
    output ibuf_entry_t        head
);

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    logic [AW:0] alloc_ptr;
    logic [AW:0] fill_ptr;
    logic [AW:0] pop_ptr;
    ibuf_entry_t mem [DEPTH];

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            pop_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            pop_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].filled <= 1'b0;
            end
        end else begin
            if (alloc) begin
                mem[alloc_ptr[AW-1:0]] <= '{pc: alloc_pc, instr: '0, filled: 1'b0};
                alloc_ptr              <= alloc_ptr + (AW+1)'(1);
            end
            if (fill) begin
                mem[fill_ptr[AW-1:0]].instr  <= fill_instr;
                mem[fill_ptr[AW-1:0]].filled <= 1'b1;
                fill_ptr                     <= fill_ptr + (AW+1)'(1);
            end
            if (pop) begin
                mem[pop_ptr[AW-1:0]].filled <= 1'b0;
                pop_ptr                     <= pop_ptr + (AW+1)'(1);
            end
        end
    end

    assign alloc_cnt = alloc_ptr - pop_ptr;
    assign pend_cnt  = alloc_ptr - fill_ptr;
    assign head      = mem[pop_ptr[AW-1:0]];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: credit-based imem requests, PC update, redirect flush and
// discard of responses still in flight for squashed requests.
//
//   state    | meaning
//   ST_RUN   | no squashed responses outstanding; responses fill the buffer
//   ST_DRAIN | squashed responses outstanding; next rvalids are discarded
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int IBUF_DEPTH = 2,
    parameter int DROP_W     = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    fetch_ctrl_if.master bus
);

    localparam int AW    = $clog2(IBUF_DEPTH);
    localparam int SUM_W = ((DROP_W > AW + 1) ? DROP_W : AW + 1) + 1;

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [DROP_W-1:0] drop_cnt;
    logic [DROP_W-1:0] drop_next;

    logic [AW:0]       alloc_cnt;
    logic [AW:0]       pend_cnt;
    ibuf_entry_t       head;

    logic              credit;
    logic              req;
    logic              grant;
    logic              pc_wren;
    logic              fill;
    logic              drop_rsp;
    logic              instr_valid;
    logic              pop;
    logic [SUM_W-1:0]  outstanding;

    fetch_ibuf #(
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk_sys    (i_clk),
        .rst_b      (i_rst),
        .flush      (bus.i_redirect),
        .alloc      (grant),
        .alloc_pc   (bus.o_imem_addr),
        .fill       (fill),
        .fill_instr (bus.i_imem_rdata),
        .pop        (pop),
        .alloc_cnt  (alloc_cnt),
        .pend_cnt   (pend_cnt),
        .head       (head)
    );

    // Squashed responses still hold credit until they return, so new requests cannot
    // overrun the buffer once those slots are reused.
    always_comb begin
        credit      = (SUM_W'(alloc_cnt) + SUM_W'(drop_cnt)) < SUM_W'(IBUF_DEPTH);
        req         = i_rst && !bus.i_redirect && credit;
        grant       = req && bus.i_imem_gnt;
        pc_wren     = i_rst && (bus.i_redirect || grant);
        drop_rsp    = bus.i_imem_rvalid && (state == ST_DRAIN);
        fill        = bus.i_imem_rvalid && !bus.i_redirect && (state == ST_RUN) && (pend_cnt != '0);
        instr_valid = head.filled && !bus.i_redirect;
        pop         = instr_valid && bus.i_instr_ready;
        outstanding = SUM_W'(drop_cnt) + SUM_W'(pend_cnt);
    end

    // On redirect every unanswered request becomes a drop; an rvalid arriving in the
    // same cycle answers the oldest of them.
    always_comb begin
        drop_next = drop_cnt;
        if (bus.i_redirect) begin
            if (bus.i_imem_rvalid && (outstanding != '0)) begin
                drop_next = DROP_W'(outstanding - SUM_W'(1));
            end else begin
                drop_next = DROP_W'(outstanding);
            end
        end else if (drop_rsp) begin
            drop_next = drop_cnt - DROP_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:   if (drop_next != '0) state_next = ST_DRAIN;
            ST_DRAIN: if (drop_next == '0) state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    assign bus.o_imem_req    = req;
    assign bus.o_imem_addr   = word_align(bus.i_pc);
    assign bus.o_pc_wren     = pc_wren;
    assign bus.o_pc_next     = !pc_wren       ? '0 :
                               bus.i_redirect ? word_align(bus.i_redirect_pc) :
                                                bus.i_pc + PC_INC;
    assign bus.o_instr_valid = instr_valid;
    assign bus.o_instr       = head.filled ? head.instr : '0;
    assign bus.o_instr_pc    = head.filled ? head.pc    : '0;

    a_no_stray_rvalid : assert property (@(posedge i_clk) disable iff (!i_rst)
        !(bus.i_imem_rvalid && (pend_cnt == '0) && (drop_cnt == '0)))
        else $warning("fetch_ctrl: rvalid with no outstanding request ignored");

    a_credit_bound : assert property (@(posedge i_clk) disable iff (!i_rst)
        (SUM_W'(alloc_cnt) + SUM_W'(drop_cnt)) <= SUM_W'(IBUF_DEPTH))
        else $error("fetch_ctrl: allocated plus dropped exceeds buffer depth");

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural PC register and a 1-cycle or hand-driven imem.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .IBUF_DEPTH (2),
        .DROP_W     (2)
    ) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] pc_q        = 32'h0;
    logic        pc_load     = 1'b0;
    logic [31:0] pc_load_val = 32'h0;
    logic        mem_auto    = 1'b1;
    logic        auto_rv;
    logic [31:0] auto_rd;
    logic        man_rv      = 1'b0;
    logic [31:0] man_rd      = 32'h0;

    always @(posedge clk) begin
        if (pc_load) pc_q <= pc_load_val;
        else if (bus.o_pc_wren) pc_q <= bus.o_pc_next;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_rv <= 1'b0;
            auto_rd <= 32'h0;
        end else begin
            auto_rv <= bus.o_imem_req && bus.i_imem_gnt;
            auto_rd <= bus.o_imem_addr ^ 32'hA5A5_0000;
        end
    end

    assign bus.i_pc          = pc_q;
    assign bus.i_imem_rvalid = mem_auto ? auto_rv : man_rv;
    assign bus.i_imem_rdata  = mem_auto ? auto_rd : man_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic req, input logic [31:0] addr,
                       input logic wren, input logic [31:0] nxt, input logic vld,
                       input logic [31:0] ipc = 32'h0, input logic [31:0] ins = 32'h0);
        @(negedge clk);
        chk({tag, ".req"},   32'(bus.o_imem_req),    32'(req));
        chk({tag, ".addr"},  bus.o_imem_addr,        addr);
        chk({tag, ".wren"},  32'(bus.o_pc_wren),     32'(wren));
        chk({tag, ".next"},  bus.o_pc_next,          nxt);
        chk({tag, ".valid"}, 32'(bus.o_instr_valid), 32'(vld));
        if (vld) begin
            chk({tag, ".ipc"},   bus.o_instr_pc, ipc);
            chk({tag, ".instr"}, bus.o_instr,    ins);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".req"},   32'(bus.o_imem_req),    32'h0);
        chk({tag, ".wren"},  32'(bus.o_pc_wren),     32'h0);
        chk({tag, ".next"},  bus.o_pc_next,          32'h0);
        chk({tag, ".valid"}, 32'(bus.o_instr_valid), 32'h0);
        chk({tag, ".instr"}, bus.o_instr,            32'h0);
        chk({tag, ".ipc"},   bus.o_instr_pc,         32'h0);
    endtask

    task automatic do_reset(input logic [31:0] pc0);
        rst_n          = 1'b0;
        man_rv         = 1'b0;
        bus.i_redirect = 1'b0;
        pc_load        = 1'b1;
        pc_load_val    = pc0;
        @(posedge clk);
        #1;
        pc_load = 1'b0;
        rst_n   = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_imem_gnt    = 1'b1;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = 32'h0;
        bus.i_instr_ready = 1'b1;
        pc_load           = 1'b1;

        // reset state with requests otherwise possible
        @(negedge clk);
        chk_zero("rst");
        @(posedge clk);
        #1;
        pc_load = 1'b0;
        rst_n   = 1'b1;

        // streaming, 1-cycle memory, decode always ready
        cyc("t1c0", 1, 32'h0, 1, 32'h4,  0);
        next_cycle(); cyc("t1c1", 1, 32'h4,  1, 32'h8,  0);
        next_cycle(); cyc("t1c2", 0, 32'h8,  0, 32'h0,  1, 32'h0, 32'hA5A5_0000);
        next_cycle(); cyc("t1c3", 1, 32'h8,  1, 32'hC,  1, 32'h4, 32'hA5A5_0004);
        next_cycle(); cyc("t1c4", 1, 32'hC,  1, 32'h10, 0);
        next_cycle(); cyc("t1c5", 0, 32'h10, 0, 32'h0,  1, 32'h8, 32'hA5A5_0008);
        next_cycle(); cyc("t1c6", 1, 32'h10, 1, 32'h14, 1, 32'hC, 32'hA5A5_000C);

        // decode stalled: buffer fills, PC holds at 0x8, then resumes without skipping
        do_reset(32'h0);
        mem_auto = 1'b1; bus.i_imem_gnt = 1'b1; bus.i_instr_ready = 1'b0;
        cyc("t2c0", 1, 32'h0, 1, 32'h4, 0);
        next_cycle(); cyc("t2c1", 1, 32'h4, 1, 32'h8, 0);
        next_cycle(); cyc("t2c2", 0, 32'h8, 0, 32'h0, 1, 32'h0, 32'hA5A5_0000);
        next_cycle(); cyc("t2c3", 0, 32'h8, 0, 32'h0, 1, 32'h0, 32'hA5A5_0000);
        next_cycle(); bus.i_instr_ready = 1'b1;
        cyc("t2c4", 0, 32'h8, 0, 32'h0, 1, 32'h0, 32'hA5A5_0000);
        next_cycle(); cyc("t2c5", 1, 32'h8, 1, 32'hC,  1, 32'h4, 32'hA5A5_0004);
        next_cycle(); cyc("t2c6", 1, 32'hC, 1, 32'h10, 0);

        // redirect with two requests in flight: both responses dropped
        do_reset(32'h10);
        mem_auto = 1'b0; bus.i_imem_gnt = 1'b1; bus.i_instr_ready = 1'b1;
        cyc("t3c0", 1, 32'h10, 1, 32'h14, 0);
        next_cycle(); cyc("t3c1", 1, 32'h14, 1, 32'h18, 0);
        next_cycle(); bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h103;
        cyc("t3c2", 0, 32'h18, 1, 32'h100, 0);
        next_cycle(); bus.i_redirect = 1'b0; man_rv = 1'b1; man_rd = 32'hDEAD_0010;
        cyc("t3c3", 0, 32'h100, 0, 32'h0, 0);
        next_cycle(); man_rd = 32'hDEAD_0014;
        cyc("t3c4", 1, 32'h100, 1, 32'h104, 0);
        next_cycle(); bus.i_imem_gnt = 1'b0; man_rd = 32'h0000_0013;
        cyc("t3c5", 1, 32'h104, 0, 32'h0, 0);
        next_cycle(); man_rv = 1'b0;
        cyc("t3c6", 1, 32'h104, 0, 32'h0, 1, 32'h100, 32'h0000_0013);

        // redirect coinciding with the 0x10 response: only 0x14 remains to drop
        do_reset(32'h10);
        mem_auto = 1'b0; bus.i_imem_gnt = 1'b1; bus.i_instr_ready = 1'b1;
        cyc("t4c0", 1, 32'h10, 1, 32'h14, 0);
        next_cycle(); cyc("t4c1", 1, 32'h14, 1, 32'h18, 0);
        next_cycle(); bus.i_redirect = 1'b1; bus.i_redirect_pc = 32'h100;
        man_rv = 1'b1; man_rd = 32'hDEAD_0010;
        cyc("t4c2", 0, 32'h18, 1, 32'h100, 0);
        next_cycle(); bus.i_redirect = 1'b0; man_rd = 32'hDEAD_0014;
        cyc("t4c3", 1, 32'h100, 1, 32'h104, 0);
        next_cycle(); bus.i_imem_gnt = 1'b0; man_rd = 32'h1111_1111;
        cyc("t4c4", 1, 32'h104, 0, 32'h0, 0);
        next_cycle(); man_rv = 1'b0;
        cyc("t4c5", 1, 32'h104, 0, 32'h0, 1, 32'h100, 32'h1111_1111);

        // grant withheld for five cycles: request and address held, PC frozen
        do_reset(32'h40);
        mem_auto = 1'b1; bus.i_imem_gnt = 1'b0; bus.i_instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) next_cycle();
            cyc($sformatf("t5w%0d", i), 1, 32'h40, 0, 32'h0, 0);
        end
        next_cycle(); bus.i_imem_gnt = 1'b1;
        cyc("t5g", 1, 32'h40, 1, 32'h44, 0);
        next_cycle(); bus.i_imem_gnt = 1'b0;
        cyc("t5c6", 1, 32'h44, 0, 32'h0, 0);
        next_cycle(); cyc("t5c7", 1, 32'h44, 0, 32'h0, 1, 32'h40, 32'hA5A5_0040);

        // async reset with two filled entries, stray rvalid afterwards, restart from i_pc
        do_reset(32'h0);
        mem_auto = 1'b1; bus.i_imem_gnt = 1'b1; bus.i_instr_ready = 1'b0;
        cyc("t6c0", 1, 32'h0, 1, 32'h4, 0);
        next_cycle(); cyc("t6c1", 1, 32'h4, 1, 32'h8, 0);
        next_cycle(); cyc("t6c2", 0, 32'h8, 0, 32'h0, 1, 32'h0, 32'hA5A5_0000);
        next_cycle(); cyc("t6c3", 0, 32'h8, 0, 32'h0, 1, 32'h0, 32'hA5A5_0000);
        rst_n = 1'b0;
        #1;
        chk_zero("t6rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1; mem_auto = 1'b0; bus.i_imem_gnt = 1'b0; bus.i_instr_ready = 1'b1;
        man_rv = 1'b1; man_rd = 32'h0BAD_0BAD;
        cyc("t6r0", 1, 32'h8, 0, 32'h0, 0);
        next_cycle(); man_rv = 1'b0; bus.i_imem_gnt = 1'b1;
        cyc("t6r1", 1, 32'h8, 1, 32'hC, 0);
        next_cycle(); bus.i_imem_gnt = 1'b0; man_rv = 1'b1; man_rd = 32'h0000_0077;
        cyc("t6r2", 1, 32'hC, 0, 32'h0, 0);
        next_cycle(); man_rv = 1'b0;
        cyc("t6r3", 1, 32'hC, 0, 32'h0, 1, 32'h8, 32'h0000_0077);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
